// File: rtl/pal_se_arbiter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// pal_se_arbiter
//
// Shares one WIDTH-bit parallel-in/serial-out shifter (MSB first) between two
// requesters. It grants round-robin, drives the shifter's load strobe and
// parallel word, and produces the framing strobes that accompany the
// shifter's serial output. A new word is never loaded before the current word
// has fully shifted out. GAP idle cycles are forced between the last bit of
// one word and the first bit of the next.
//
// Ports:
//   clk        rising-edge system clock
//   reset      synchronous, active-high reset
//   req0/req1  requester has a word pending (held until its ack)
//   din0/din1  requester words, stable while the request is high
//   ack0/ack1  one-cycle pulse: that requester's word was taken this cycle
//   ser_load   load strobe to the shifter (captured at the end of the cycle)
//   ser_data   parallel word to the shifter, qualified by ser_load
//   ser_valid  shifter serial output carries a valid bit this cycle
//   ser_last   serial output carries the final (LSB) bit of the word
//   ser_src    id of the requester whose word is loading/shifting
//   busy       a word is in flight or the inter-word gap is pending
//
// All outputs are registered.
// ---------------------------------------------------------------------------
module pal_se_arbiter #(
    parameter int WIDTH = 4,
    parameter int GAP   = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] din0,
    output logic             ack0,
    input  logic             req1,
    input  logic [WIDTH-1:0] din1,
    output logic             ack1,
    output logic             ser_load,
    output logic [WIDTH-1:0] ser_data,
    output logic             ser_valid,
    output logic             ser_last,
    output logic             ser_src,
    output logic             busy
);

    localparam int CNTW = $clog2(WIDTH + GAP + 1);

    // cnt_q holds the index of the current cycle relative to the load cycle
    // (load cycle = 0). Index WIDTH carries the last bit; index WIDTH+GAP is
    // the earliest cycle in which the next word may be loaded. With GAP=0
    // that load overlaps the last bit, which is legal because the shifter
    // only replaces its contents at the end of the cycle.
    localparam logic [CNTW-1:0] LAST_IDX  = CNTW'(WIDTH);
    localparam logic [CNTW-1:0] FRAME_END = CNTW'(WIDTH + GAP);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [CNTW-1:0]  nextIdx;
    logic             rrPtr_q, rrPtr_d;
    logic             ack0_q, ack0_d;
    logic             ack1_q, ack1_d;
    logic             load_q, load_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             last_q, last_d;
    logic             src_q, src_d;
    logic             busy_q, busy_d;
    logic             anyReq;
    logic             winner;
    logic             grant;

    // rrPtr_q remembers the last requester served; on a tie the other one
    // wins, a lone request is granted straight away.
    assign anyReq  = req0 | req1;
    assign winner  = (req0 & req1) ? ~rrPtr_q : req1;
    assign nextIdx = cnt_q + CNTW'(1);

    // Next-state and registered-output logic. Strobes default low each
    // cycle; ser_data and ser_src hold their last loaded values.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rrPtr_d = rrPtr_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        load_d  = 1'b0;
        data_d  = data_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        src_d   = src_q;
        busy_d  = 1'b0;
        grant   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                grant = anyReq;
            end
            ST_SHIFT, ST_GAP: begin
                busy_d  = 1'b1;
                valid_d = (nextIdx <= LAST_IDX);
                last_d  = (nextIdx == LAST_IDX);
                cnt_d   = nextIdx;
                state_d = (nextIdx <= LAST_IDX) ? ST_SHIFT : ST_GAP;
                // The final cycle of the frame either loads the next word or
                // finishes the frame (still busy) before dropping to idle.
                if (nextIdx == FRAME_END) begin
                    if (anyReq) begin
                        grant = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Loading a word leaves valid/last alone so a back-to-back load still
        // carries the previous word's final bit.
        if (grant) begin
            load_d  = 1'b1;
            data_d  = winner ? din1 : din0;
            ack0_d  = ~winner;
            ack1_d  = winner;
            src_d   = winner;
            busy_d  = 1'b1;
            state_d = ST_SHIFT;
            cnt_d   = '0;
            rrPtr_d = winner;
        end
    end

    // State and output registers. Reset abandons any word in flight and
    // points the round-robin at requester 1 so requester 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rrPtr_q <= 1'b1;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            load_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            src_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rrPtr_q <= rrPtr_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            load_q  <= load_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            src_q   <= src_d;
            busy_q  <= busy_d;
        end
    end

    assign ack0      = ack0_q;
    assign ack1      = ack1_q;
    assign ser_load  = load_q;
    assign ser_data  = data_q;
    assign ser_valid = valid_q;
    assign ser_last  = last_q;
    assign ser_src   = src_q;
    assign busy      = busy_q;

endmodule
